// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv unit: FSM state encoding, default width
// and the signed-overflow operand constants.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] divisor_ext;

  always_comb begin
    shifted     = {rem, dividend_msb};
    divisor_ext = {2'b00, divisor};
    q_bit       = (shifted >= divisor_ext);
    rem_next    = q_bit ? (WIDTH+1)'(shifted - divisor_ext) : shifted[WIDTH:0];
  end

endmodule

// File: rtl/div_module.sv
// Iterative signed divider for the multdiv unit: one quotient bit per cycle,
// with the same inputRDY/resultRDY/exception handshake as the multiplier.
module div_module
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] data_operandA,
  input  logic signed [WIDTH-1:0] data_operandB,
  input  logic                    ctrl_DIV,
  output logic        [WIDTH-1:0] data_result,
  output logic                    data_exception,
  output logic                    data_inputRDY,
  output logic                    data_resultRDY
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] INT_MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] NEG_ONE_W = '1;

  // Magnitude as an unsigned value; the most negative number maps to itself.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] q,
                                                  input logic neg);
    return neg ? -q : q;
  endfunction

  state_e           state;
  logic [CNT_W-1:0] counter;

  logic [WIDTH:0]   rem_p0;
  logic [WIDTH-1:0] quo_p0;
  logic [WIDTH-1:0] divisor_p0;
  logic             sign_q_p0;

  logic [WIDTH:0]   rem_next;
  logic             q_bit;
  logic             accept;
  logic             div_by_zero;
  logic             overflow;

  assign data_inputRDY  = (state == IDLE) || (state == DONE);
  assign data_resultRDY = (state == DONE);
  assign accept         = data_inputRDY && ctrl_DIV;
  assign div_by_zero    = ($unsigned(data_operandB) == '0);
  assign overflow       = ($unsigned(data_operandA) == INT_MIN_W) &&
                          ($unsigned(data_operandB) == NEG_ONE_W);

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem          (rem_p0),
    .dividend_msb (quo_p0[WIDTH-1]),
    .divisor      (divisor_p0),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  // Control: FSM, iteration counter and the architecturally visible result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      counter        <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (ctrl_DIV) begin
            if (div_by_zero) begin
              data_result    <= '0;
              data_exception <= 1'b1;
              state          <= DONE;
            end else if (overflow) begin
              data_result    <= INT_MIN_W;
              data_exception <= 1'b1;
              state          <= DONE;
            end else begin
              counter <= CNT_W'(WIDTH - 1);
              state   <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          counter <= counter - CNT_W'(1);
          if (counter == '0) state <= FIX;
        end
        FIX: begin
          data_result    <= apply_sign(quo_p0, sign_q_p0);
          data_exception <= 1'b0;
          state          <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: operand magnitudes captured on accept, then one step per RUN cycle.
  // The dividend register shifts out its msb and takes in quotient bits at the lsb.
  always_ff @(posedge clock) begin
    if (accept) begin
      divisor_p0 <= magnitude(data_operandB);
      quo_p0     <= magnitude(data_operandA);
      rem_p0     <= '0;
      sign_q_p0  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
    end else if (state == RUN) begin
      rem_p0 <= rem_next;
      quo_p0 <= {quo_p0[WIDTH-2:0], q_bit};
    end
  end

endmodule

// File: tb/tb_div_module.sv
// Directed bench for div_module: vector table plus busy, back-to-back and
// reset sequences.
module tb_div_module;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_inputRDY;
  logic        data_resultRDY;

  int n_cmp;
  int n_fail;

  div_module #(
    .WIDTH(32)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_inputRDY  (data_inputRDY),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        exc;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one start strobe; returns after the capture edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    tick();
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h0BAD_F00D;
  endtask

  // Called right after the capture edge (latency 1 so far).
  task automatic wait_result(input string name, input logic [31:0] exp_q,
                             input logic exp_exc, input int exp_lat);
    int lat;
    lat = 1;
    while (!data_resultRDY && lat < 60) begin
      tick();
      lat++;
    end
    check({name, "_rdy"}, 32'(data_resultRDY), 32'd1);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_q"}, data_result, exp_q);
    check({name, "_exc"}, 32'(data_exception), 32'(exp_exc));
  endtask

  initial begin
    int pulses;
    int first_pulse;
    logic [31:0] pulse_q;

    n_cmp  = 0;
    n_fail = 0;
    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;

    vecs[0]  = '{"p100_p7",   32'd100,        32'd7,          32'd14,         1'b0, 34};
    vecs[1]  = '{"m100_p7",   32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0, 34};
    vecs[2]  = '{"p100_m7",   32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  1'b0, 34};
    vecs[3]  = '{"m100_m7",   32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0, 34};
    vecs[4]  = '{"p5_p9",     32'd5,          32'd9,          32'd0,          1'b0, 34};
    vecs[5]  = '{"m1_p2",     32'hFFFF_FFFF,  32'd2,          32'd0,          1'b0, 34};
    vecs[6]  = '{"m7_p2",     32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 34};
    vecs[7]  = '{"p7_zero",   32'd7,          32'd0,          32'd0,          1'b1, 1};
    vecs[8]  = '{"ovf",       32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, 1};
    vecs[9]  = '{"min_p1",    32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, 34};
    vecs[10] = '{"m5_zero",   32'hFFFF_FFFB,  32'd0,          32'd0,          1'b1, 1};
    vecs[11] = '{"max_m1",    32'h7FFF_FFFF,  32'hFFFF_FFFF,  32'h8000_0001,  1'b0, 34};
    vecs[12] = '{"min_p2",    32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0, 34};

    tick();
    tick();
    check("rst_result", data_result, 32'd0);
    check("rst_exc", 32'(data_exception), 32'd0);
    check("rst_resrdy", 32'(data_resultRDY), 32'd0);
    check("rst_inrdy", 32'(data_inputRDY), 32'd1);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      if (vecs[i].lat > 1) check({vecs[i].name, "_busy"}, 32'(data_inputRDY), 32'd0);
      wait_result(vecs[i].name, vecs[i].q, vecs[i].exc, vecs[i].lat);
      check({vecs[i].name, "_inrdy_done"}, 32'(data_inputRDY), 32'd1);
      tick();
      check({vecs[i].name, "_pulse_end"}, 32'(data_resultRDY), 32'd0);
      check({vecs[i].name, "_hold"}, data_result, vecs[i].q);
      check({vecs[i].name, "_inrdy_idle"}, 32'(data_inputRDY), 32'd1);
    end

    // Strobes during RUN must neither restart nor corrupt the operation.
    start_op(32'd1000, 32'd10);
    pulses = 0;
    first_pulse = 0;
    pulse_q = '0;
    for (int c = 2; c <= 60; c++) begin
      if (c == 5 || c == 20) begin
        ctrl_DIV = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd3;
      end else begin
        ctrl_DIV = 1'b0;
      end
      tick();
      if (data_resultRDY) begin
        pulses++;
        if (first_pulse == 0) begin
          first_pulse = c;
          pulse_q = data_result;
        end
      end
    end
    ctrl_DIV = 1'b0;
    check("busy_pulses", 32'(pulses), 32'd1);
    check("busy_lat", 32'(first_pulse), 32'd34);
    check("busy_q", pulse_q, 32'd100);

    // New operands accepted in the DONE cycle.
    tick();
    start_op(32'd1000, 32'd10);
    wait_result("b2b_first", 32'd100, 1'b0, 34);
    start_op(32'd20, 32'd4);
    check("b2b_busy", 32'(data_inputRDY), 32'd0);
    wait_result("b2b_second", 32'd5, 1'b0, 34);
    tick();

    // Reset in the middle of RUN aborts with no trailing pulse.
    start_op(32'd1000, 32'd10);
    for (int c = 2; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_result", data_result, 32'd0);
    check("midrst_exc", 32'(data_exception), 32'd0);
    check("midrst_inrdy", 32'(data_inputRDY), 32'd1);
    check("midrst_resrdy", 32'(data_resultRDY), 32'd0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (data_resultRDY) pulses++;
    end
    check("midrst_nopulse", 32'(pulses), 32'd0);
    start_op(32'd20, 32'd4);
    wait_result("after_rst", 32'd5, 1'b0, 34);
    tick();

    // Reset wins over a simultaneous start strobe.
    reset = 1'b1;
    start_op(32'd7, 32'd0);
    reset = 1'b0;
    check("rstprio_resrdy", 32'(data_resultRDY), 32'd0);
    check("rstprio_exc", 32'(data_exception), 32'd0);
    check("rstprio_inrdy", 32'(data_inputRDY), 32'd1);
    tick();
    check("rstprio_idle", 32'(data_resultRDY), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div_module.md
Name: div_module

Overview:
- Iterative signed 32-bit integer divider for the multdiv unit. It is the counterpart of the multiplier.
- It takes dividend and divisor on a one-cycle start strobe and computes one quotient bit per cycle (radix-2 restoring).
- It presents the quotient with the same inputRDY/resultRDY/exception handshake the pipeline uses for multiply.

Parameters:
WIDTH, 32, operand/quotient width; iteration count equals WIDTH

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
data_operandA  input  WIDTH  dividend, two's complement
data_operandB  input  WIDTH  divisor, two's complement
ctrl_DIV  input  1  start strobe, sampled at rising edge
data_result  output  WIDTH  quotient, truncated toward zero
data_exception  output  1  divide-by-zero or overflow flag for current result
data_inputRDY  output  1  high when a new ctrl_DIV is accepted
data_resultRDY  output  1  one-cycle pulse: data_result/data_exception valid

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high; ports named clock and reset.
- Reset values: data_result=0, data_exception=0, data_resultRDY=0, data_inputRDY=1, state=IDLE, counter=0.
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE: inputRDY=1. ctrl_DIV=1 at an edge captures both operands and goes to RUN, or to DONE directly for the special cases below.
- Capture:
  - Store |A| and |B| (unsigned, WIDTH bits; |0x80000000| = 0x80000000 unsigned).
  - Store sign_q = A[msb]^B[msb].
  - Clear partial remainder (WIDTH+1 bits) and set counter=WIDTH-1.
- RUN, one iteration per edge:
  - rem = {rem, q_msb}; shift quotient left.
  - If rem >= |B|: rem -= |B| and set q lsb=1.
  - Counter decrements; after the iteration with counter==0, go to FIX.
  - RUN lasts exactly WIDTH cycles.
- FIX (one cycle): data_result = sign_q ? -q : q; data_exception=0; then DONE.
- DONE: data_resultRDY=1 for exactly this one cycle. data_result/data_exception hold until the next capture edge.
  - Without a new ctrl_DIV, DONE goes to IDLE.
  - With ctrl_DIV=1, DONE captures the new operands (back-to-back operation).
- Latency: capture at edge E; data_resultRDY high in the cycle after edge E+WIDTH+1 (34 cycles for WIDTH=32).
- Divide by zero (B==0 at capture): skip RUN/FIX and go straight to DONE with data_result=0, data_exception=1. resultRDY is high in the cycle after edge E.
- Overflow (A==0x80000000, B==0xFFFFFFFF): take the same 1-cycle path with data_result=0x80000000, data_exception=1.
- inputRDY=0 in RUN and FIX. ctrl_DIV during RUN/FIX is ignored: no restart, no corruption of the in-flight operation.
- Operand inputs are don't-care except at the capture edge.
- Reset asserted at any point, including mid-RUN, aborts the operation. All outputs take their reset values at that edge and no resultRDY pulse follows.
- Reset has priority over ctrl_DIV at the same edge.
- Remainder is internal only (sign follows dividend) and is not exported.

Decomposition:
- Shared package multdiv_pkg:
  - state enum (IDLE, RUN, FIX, DONE);
  - WIDTH default;
  - constants INT_MIN=0x80000000 and NEG_ONE=0xFFFFFFFF;
  - shared by the multiplier path and the pipeline's multdiv stall logic.
- One sub-module, div_step: combinational single iteration. Inputs: rem, dividend msb, divisor. Outputs: next rem, quotient bit. It keeps the FSM/counter file small and is unit-testable.

Test Plan:
- Basic: reset 2 cycles, then A=100, B=7, ctrl_DIV 1 cycle -> inputRDY drops next cycle; resultRDY pulses exactly 34 cycles after capture; result=14, exception=0; inputRDY=1 again.
- Signs: A=-100/B=7 -> 0xFFFFFFF2 (-14); 100/-7 -> -14; -100/-7 -> 14; A=5, B=9 -> 0; A=-1, B=2 -> 0 (truncation toward zero).
- Exceptions:
  - A=7, B=0 -> resultRDY in the cycle after capture, result=0, exception=1.
  - A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1, 1-cycle latency.
  - A=0x80000000, B=1 -> 0x80000000, exception=0 after 34 cycles.
- Busy ignore: start 1000/10, pulse ctrl_DIV with A=9, B=3 at cycle 5 and cycle 20 -> single resultRDY at cycle 34 with result=100; no second pulse.
- Back-to-back: assert ctrl_DIV with A=20, B=4 during the DONE cycle of a 1000/10 op -> result=100 on first pulse, then result=5 exactly 34 cycles later.
- Reset mid-op: start 1000/10, assert reset at cycle 10 -> next cycle result=0, exception=0, inputRDY=1, no resultRDY afterward; then 20/4 -> 5 after 34 cycles.
